alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
Parametrised, registered successor to the LEGv8 ALU control decoder.
- Decodes aluop/funct into a 4-bit ALU control word, extending the opcode set with LSL, LSR and an iterative MUL.
- Sits between main decoder and EX stage, with valid/ready handshakes on both sides.
- Sequences multi-cycle MUL by emitting one control beat per iteration with step index and first/last markers.

Parameters:
- MUL_ITERS, 64: beats per MUL, ≥2. Normally equals datapath width, one shift-add step per beat.
- STEP_W, $clog2(MUL_ITERS): width of mul_step (derived localparam, not overridable).

Ports:
- clk in 1: clock, rising edge.
- reset in 1: synchronous, active-high.
- in_valid in 1: decode request valid.
- in_ready out 1: block accepts request this cycle.
- funct in 11: instruction bits [31:21].
- aluop in 2: 00 mem, 01 CBZ, 10 R-type, 11 reserved.
- out_valid out 1: control beat valid.
- out_ready in 1: EX accepts beat.
- alucontrol out 4: ALU control word.
- mul_step out STEP_W: current MUL iteration.
- mul_first out 1: beat is MUL step 0.
- mul_last out 1: beat is MUL step MUL_ITERS-1.
- illegal out 1: current beat came from undecodable request.

Behaviour:
- One clock (clk), synchronous active-high reset (reset); all state updates on rising clk.
- Decode table:
  - aluop 00 → 0010.
  - aluop 01 → 0111.
  - aluop 10 by funct: ADD 10001011000 → 0010, SUB 11001011000 → 0110, AND 10001010000 → 0000, ORR 10101010000 → 0001, LSL 11010011011 → 0011, LSR 11010011010 → 0100, MUL 10011011000 → 1000 (multi-cycle).
  - Anything else (other funct, or aluop 11) → 0000 with illegal=1.
- Latency: request accepted in cycle t appears on outputs with out_valid=1 in cycle t+1. No combinational path from in_* to out_*.
- Accept condition: accept = in_valid & in_ready. An accept in the same cycle a beat retires replaces it back-to-back with no bubble.
- FSM states:
  - IDLE: out_valid=0, in_ready=1. Accept of single-cycle op → SINGLE. Accept of MUL → MULTI with step=0.
  - SINGLE: out_valid=1, in_ready=out_ready. On out_ready: next accept → SINGLE/MULTI, else → IDLE.
  - MULTI: out_valid=1, alucontrol=1000, in_ready=out_ready & mul_last. On out_ready & !mul_last: step+1. On out_ready & mul_last: next accept → SINGLE/MULTI, else → IDLE.
- Stall: out_ready=0 holds alucontrol, mul_step, mul_first, mul_last, illegal and state unchanged.
- mul_first and mul_last are 0 outside MULTI. mul_step is 0 outside MULTI. Step never wraps within an op.
- Reset values: state IDLE, out_valid 0, alucontrol 0000, mul_step 0, mul_first 0, mul_last 0, illegal 0, in_ready 1 from the first post-reset cycle.
- Reset mid-MUL abandons the op. The next cycle is IDLE.
- Reset wins over a simultaneous accept; the request is dropped.

Optional Feature:
ALU_CTRL_ILLEGAL_TRAP_EN
- Defined: an illegal request produces no beat. State returns to or stays IDLE. illegal pulses high for exactly one cycle (t+1) with out_valid=0.
- Undefined: an illegal request produces a normal SINGLE beat, alucontrol=0000 and illegal=1 (legacy fallback behaviour).

Decomposition:
- Package alu_ctrl_pkg:
  - funct constants: FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_ORR, FUNCT_LSL, FUNCT_LSR, FUNCT_MUL.
  - aluop constants.
  - alucontrol encodings: ALU_AND, ALU_OR, ALU_ADD, ALU_LSL, ALU_LSR, ALU_SUB, ALU_PASSB (0111), ALU_MUL.
  - state enum: IDLE, SINGLE, MULTI.
- Sub-module alu_funct_decode: purely combinational, maps aluop/funct to {alucontrol, is_multi, is_illegal}. The top level holds the FSM and registers.

Test Plan:
- Reset with in_valid=1 → all outputs at reset values; first post-reset cycle in_ready=1, out_valid=0.
- Back-to-back ADD, SUB, ORR, LSR with out_ready=1 → alucontrol 0010, 0110, 0001, 0100 on consecutive cycles t+1..t+4, no bubbles.
- MUL with MUL_ITERS=4, out_ready=1 → four beats of 1000 with mul_step 0,1,2,3. mul_first only on step 0, mul_last only on step 3. in_ready=0 for the first three beats, then a SUB is accepted on the last beat and appears the next cycle.
- MUL with out_ready dropped at step 2 for 3 cycles → mul_step stays 2 and outputs stay stable; completes in 4+3 cycles.
- funct 11111111111 with aluop 10:
  - Undefined macro → one beat alucontrol 0000, illegal=1.
  - Defined macro → illegal pulse, out_valid=0.
- reset asserted at MUL step 1 → next cycle IDLE, out_valid=0, mul_step 0; subsequent CBZ → 0111.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants and types for the ALU control sequencer.
//   - FUNCT_*  : R-type instruction bits [31:21] recognised by the decoder
//   - ALUOP_*  : main-decoder aluop field values
//   - ALU_*    : 4-bit ALU control word encodings
//   - state_t  : sequencer FSM state (IDLE, SINGLE, MULTI)
package alu_ctrl_pkg;

    localparam logic [10:0] FUNCT_ADD = 11'b10001011000;
    localparam logic [10:0] FUNCT_SUB = 11'b11001011000;
    localparam logic [10:0] FUNCT_AND = 11'b10001010000;
    localparam logic [10:0] FUNCT_ORR = 11'b10101010000;
    localparam logic [10:0] FUNCT_LSL = 11'b11010011011;
    localparam logic [10:0] FUNCT_LSR = 11'b11010011010;
    localparam logic [10:0] FUNCT_MUL = 11'b10011011000;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: combinational aluop/funct -> ALU control decoder.
//   aluop_i      [1:0]  : main-decoder aluop
//   funct_i      [10:0] : instruction bits [31:21]
//   alucontrol_o [3:0]  : ALU control word (0000 for undecodable requests)
//   is_multi_o          : request is the multi-cycle MUL
//   is_illegal_o        : request cannot be decoded (unknown funct or aluop 11)
module alu_funct_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0]  aluop_i,
    input  logic [10:0] funct_i,
    output logic [3:0]  alucontrol_o,
    output logic        is_multi_o,
    output logic        is_illegal_o
);

    always_comb begin
        alucontrol_o = ALU_AND;
        is_multi_o   = 1'b0;
        is_illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_MEM: alucontrol_o = ALU_ADD;
            ALUOP_CBZ: alucontrol_o = ALU_PASSB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: alucontrol_o = ALU_ADD;
                    FUNCT_SUB: alucontrol_o = ALU_SUB;
                    FUNCT_AND: alucontrol_o = ALU_AND;
                    FUNCT_ORR: alucontrol_o = ALU_OR;
                    FUNCT_LSL: alucontrol_o = ALU_LSL;
                    FUNCT_LSR: alucontrol_o = ALU_LSR;
                    FUNCT_MUL: begin
                        alucontrol_o = ALU_MUL;
                        is_multi_o   = 1'b1;
                    end
                    default: is_illegal_o = 1'b1;
                endcase
            end
            default: is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with multi-cycle MUL sequencing.
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   : request handshake from the main decoder
//   funct [10:0], aluop   : request payload
//   out_valid / out_ready : control-beat handshake towards EX
//   alucontrol [3:0]      : ALU control word of the current beat
//   mul_step [STEP_W-1:0] : MUL iteration index (0 outside MUL)
//   mul_first / mul_last  : beat is MUL step 0 / step MUL_ITERS-1
//   illegal               : beat (or trap pulse) came from an undecodable request
//   dbg_state             : current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. out_valid and the beat fields depend only on registers; in_ready
// depends on registers and out_ready only. While out_ready is low every beat
// field and the state hold.
// Build option ALU_CTRL_ILLEGAL_TRAP_EN: when defined, an illegal request
// produces no beat, only a one-cycle illegal pulse with out_valid low; when
// undefined it produces an ordinary single beat with alucontrol 0000, illegal 1.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter  int MUL_ITERS = 64,
    localparam int STEP_W    = $clog2(MUL_ITERS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       funct,
    input  logic [1:0]        aluop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alucontrol,
    output logic [STEP_W-1:0] mul_step,
    output logic              mul_first,
    output logic              mul_last,
    output logic              illegal,
    output state_t            dbg_state
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_ITERS - 1);

    state_t            state_q, state_d;
    logic [3:0]        alu_q, alu_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              illegal_q, illegal_d;

    logic [3:0] dec_alu;
    logic       dec_multi;
    logic       dec_illegal;
    logic       is_last;
    logic       advance;

    alu_funct_decode u_decode (
        .aluop_i      (aluop),
        .funct_i      (funct),
        .alucontrol_o (dec_alu),
        .is_multi_o   (dec_multi),
        .is_illegal_o (dec_illegal)
    );

    assign is_last = (state_q == MULTI) && (step_q == LAST_STEP);

    // The current beat leaves (or there is none) exactly when a new request
    // may enter, so "advance" doubles as in_ready and accept = in_valid here.
    assign advance = (state_q == IDLE) ||
                     (out_ready && ((state_q == SINGLE) || is_last));

    always_comb begin
        state_d   = state_q;
        alu_d     = alu_q;
        step_d    = step_q;
        illegal_d = illegal_q;
        if (advance) begin
            state_d   = IDLE;
            alu_d     = ALU_AND;
            step_d    = '0;
            illegal_d = 1'b0;
            if (in_valid) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                end else
`endif
                if (dec_multi) begin
                    state_d = MULTI;
                    alu_d   = ALU_MUL;
                end else begin
                    state_d   = SINGLE;
                    alu_d     = dec_alu;
                    illegal_d = dec_illegal;
                end
            end
        end else if ((state_q == MULTI) && out_ready) begin
            step_d = step_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            alu_q     <= ALU_AND;
            step_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_q     <= alu_d;
            step_q    <= step_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready   = advance;
    assign out_valid  = (state_q != IDLE);
    assign alucontrol = alu_q;
    assign mul_step   = step_q;
    assign mul_first  = (state_q == MULTI) && (step_q == '0);
    assign mul_last   = is_last;
    assign illegal    = illegal_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;
    import alu_ctrl_pkg::*;

    localparam int ITERS = 4;
    localparam int SW    = $clog2(ITERS);
    localparam int BW    = 7 + SW;   // {ill, last, first, step, alu}

    localparam logic [10:0] F_ADD = 11'b10001011000;
    localparam logic [10:0] F_SUB = 11'b11001011000;
    localparam logic [10:0] F_AND = 11'b10001010000;
    localparam logic [10:0] F_ORR = 11'b10101010000;
    localparam logic [10:0] F_LSL = 11'b11010011011;
    localparam logic [10:0] F_LSR = 11'b11010011010;
    localparam logic [10:0] F_MUL = 11'b10011011000;
    localparam logic [10:0] F_BAD = 11'b11111111111;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [10:0]   funct = '0;
    logic [1:0]    aluop = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    alucontrol;
    logic [SW-1:0] mul_step;
    logic          mul_first;
    logic          mul_last;
    logic          illegal;
    state_t        dbg_state;

    int checks = 0;
    int errors = 0;

    alu_ctrl_seq #(.MUL_ITERS(ITERS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct      (funct),
        .aluop      (aluop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alucontrol (alucontrol),
        .mul_step   (mul_step),
        .mul_first  (mul_first),
        .mul_last   (mul_last),
        .illegal    (illegal),
        .dbg_state  (dbg_state)
    );

    // drivers: inputs change 1 time unit after the rising edge, outputs are
    // sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // reference decode straight from the decode table
    function automatic void ref_decode(input logic [1:0] op, input logic [10:0] f,
                                       output logic [3:0] alu, output bit mul, output bit ill);
        alu = 4'b0000; mul = 1'b0; ill = 1'b0;
        if (op == 2'b00) alu = 4'b0010;
        else if (op == 2'b01) alu = 4'b0111;
        else if (op == 2'b10) begin
            if (f == F_ADD) alu = 4'b0010;
            else if (f == F_SUB) alu = 4'b0110;
            else if (f == F_AND) alu = 4'b0000;
            else if (f == F_ORR) alu = 4'b0001;
            else if (f == F_LSL) alu = 4'b0011;
            else if (f == F_LSR) alu = 4'b0100;
            else if (f == F_MUL) begin alu = 4'b1000; mul = 1'b1; end
            else ill = 1'b1;
        end else ill = 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; aluop = 2'b10; funct = F_ADD; out_ready = 1'b1;
        repeat (2) tick();
        samp();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b expected 0", out_valid); end
        checks++; if (alucontrol !== 4'b0000) begin errors++; $display("FAIL rst_alucontrol got %b expected 0000", alucontrol); end
        checks++; if (mul_step !== '0) begin errors++; $display("FAIL rst_mul_step got %0d expected 0", mul_step); end
        checks++; if ({mul_first, mul_last, illegal} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b expected 000", {mul_first, mul_last, illegal}); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got %0d expected IDLE", dbg_state); end
        tick();
        reset = 1'b0; in_valid = 1'b0;
        samp();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid (request under reset not dropped) got %0b expected 0", out_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [10:0] fs [4];
        logic [3:0]  ex [4];
        fs = '{F_ADD, F_SUB, F_ORR, F_LSR};
        ex = '{4'b0010, 4'b0110, 4'b0001, 4'b0100};
        out_ready = 1'b1; aluop = 2'b10;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin in_valid = 1'b1; funct = fs[i]; end
            else in_valid = 1'b0;
            samp();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %0b expected 1", i, in_ready); end
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid[%0d] got %0b expected 1", i, out_valid); end
                checks++; if (alucontrol !== ex[i-1]) begin errors++; $display("FAIL b2b_alucontrol[%0d] got %b expected %b", i, alucontrol, ex[i-1]); end
                checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL b2b_illegal[%0d] got %0b expected 0", i, illegal); end
            end
            tick();
        end
        samp();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b expected 0", out_valid); end
        tick();
    endtask

    task automatic test_mul();
        out_ready = 1'b1; aluop = 2'b10; funct = F_MUL; in_valid = 1'b1;
        tick();
        funct = F_SUB;
        for (int k = 0; k < ITERS; k++) begin
            samp();
            checks++; if (out_valid !== 1'b1 || alucontrol !== 4'b1000) begin errors++; $display("FAIL mul_beat[%0d] got v=%0b alu=%b expected v=1 alu=1000", k, out_valid, alucontrol); end
            checks++; if (mul_step !== SW'(k)) begin errors++; $display("FAIL mul_step[%0d] got %0d expected %0d", k, mul_step, k); end
            checks++; if (mul_first !== (k == 0) || mul_last !== (k == ITERS-1)) begin errors++; $display("FAIL mul_marks[%0d] got f=%0b l=%0b expected f=%0b l=%0b", k, mul_first, mul_last, k == 0, k == ITERS-1); end
            checks++; if (in_ready !== (k == ITERS-1)) begin errors++; $display("FAIL mul_in_ready[%0d] got %0b expected %0b", k, in_ready, k == ITERS-1); end
            tick();
        end
        in_valid = 1'b0;
        samp();
        checks++; if (out_valid !== 1'b1 || alucontrol !== 4'b0110) begin errors++; $display("FAIL mul_then_sub got v=%0b alu=%b expected v=1 alu=0110", out_valid, alucontrol); end
        checks++; if ({mul_first, mul_last} !== 2'b00 || mul_step !== '0) begin errors++; $display("FAIL mul_then_sub_marks got f=%0b l=%0b s=%0d expected 0 0 0", mul_first, mul_last, mul_step); end
        tick();
    endtask

    task automatic test_mul_stall();
        logic [SW-1:0] es [7];
        es = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
        out_ready = 1'b1; aluop = 2'b10; funct = F_MUL; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            samp();
            checks++; if (out_valid !== 1'b1 || alucontrol !== 4'b1000) begin errors++; $display("FAIL stall_beat[%0d] got v=%0b alu=%b expected v=1 alu=1000", c, out_valid, alucontrol); end
            checks++; if (mul_step !== es[c]) begin errors++; $display("FAIL stall_step[%0d] got %0d expected %0d", c, mul_step, es[c]); end
            checks++; if (mul_first !== (es[c] == 0) || mul_last !== (es[c] == SW'(ITERS-1))) begin errors++; $display("FAIL stall_marks[%0d] got f=%0b l=%0b", c, mul_first, mul_last); end
            tick();
        end
        out_ready = 1'b1;
        samp();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_done got %0b expected 0", out_valid); end
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; aluop = 2'b10; funct = F_BAD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        samp();
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %0b expected 1", illegal); end
        checks++; if (out_valid !== !TRAP) begin errors++; $display("FAIL ill_out_valid got %0b expected %0b", out_valid, !TRAP); end
        checks++; if (alucontrol !== 4'b0000) begin errors++; $display("FAIL ill_alucontrol got %b expected 0000", alucontrol); end
        tick();
        samp();
        checks++; if (out_valid !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL ill_after got v=%0b ill=%0b expected 0 0", out_valid, illegal); end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1; aluop = 2'b10; funct = F_MUL; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        samp();
        checks++; if (mul_step !== SW'(1)) begin errors++; $display("FAIL rmm_pre_step got %0d expected 1", mul_step); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        samp();
        checks++; if (out_valid !== 1'b0 || mul_step !== '0 || dbg_state !== IDLE) begin errors++; $display("FAIL rmm_idle got v=%0b s=%0d st=%0d expected 0 0 IDLE", out_valid, mul_step, dbg_state); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmm_in_ready got %0b expected 1", in_ready); end
        aluop = 2'b01; funct = F_BAD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        samp();
        checks++; if (out_valid !== 1'b1 || alucontrol !== 4'b0111 || illegal !== 1'b0) begin errors++; $display("FAIL rmm_cbz got v=%0b alu=%b ill=%0b expected 1 0111 0", out_valid, alucontrol, illegal); end
        tick();
    endtask

    // Random traffic against a beat-queue model: every accepted request
    // enqueues the beats it must produce; the head of the queue is what the
    // outputs must show, and a new request can enter only when the queue is
    // empty or its last beat is leaving.
    task automatic test_random();
        logic [BW-1:0] exp_q[$];
        logic [10:0]   tbl [7];
        logic [3:0]    r_alu;
        bit            r_mul, r_ill, pulse, pulse_next, exp_v, exp_ir;
        logic [BW-1:0] b;
        int            r;
        tbl = '{F_ADD, F_SUB, F_AND, F_ORR, F_LSL, F_LSR, F_MUL};
        pulse = 1'b0;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            aluop = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b11 : 2'b10;
            r = $urandom_range(0, 7);
            funct = (r < 7) ? tbl[r] : 11'($urandom_range(0, 2047));
            samp();
            exp_v  = (exp_q.size() != 0);
            exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rnd_out_valid[%0d] got %0b expected %0b", n, out_valid, exp_v); end
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL rnd_in_ready[%0d] got %0b expected %0b", n, in_ready, exp_ir); end
            if (exp_v) begin
                b = exp_q[0];
                checks++; if ({illegal, mul_last, mul_first, mul_step, alucontrol} !== b) begin errors++; $display("FAIL rnd_beat[%0d] got %b expected %b", n, {illegal, mul_last, mul_first, mul_step, alucontrol}, b); end
            end else begin
                checks++; if ({illegal, mul_last, mul_first, mul_step} !== {pulse, 2'b00, SW'(0)}) begin errors++; $display("FAIL rnd_idle[%0d] got %b expected ill=%0b rest 0", n, {illegal, mul_last, mul_first, mul_step}, pulse); end
            end
            pulse_next = 1'b0;
            if (exp_v && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_ir) begin
                ref_decode(aluop, funct, r_alu, r_mul, r_ill);
                if (r_ill && TRAP) pulse_next = 1'b1;
                else if (r_mul) begin
                    for (int k = 0; k < ITERS; k++)
                        exp_q.push_back({1'b0, k == ITERS-1, k == 0, SW'(k), 4'b1000});
                end else exp_q.push_back({r_ill, 1'b0, 1'b0, SW'(0), r_alu});
            end
            pulse = pulse_next;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (ITERS + 2) tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul();
        test_mul_stall();
        test_illegal();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
